// File: rtl/mdu_sequencer_if.sv
// ----------------------------------------------------------------------------
// mdu_sequencer_if
//   Bundle between the EX stage / hazard logic and the multiply-divide unit.
//   master : pipeline side (drives start/op/operands/MFHI-MFLO requests)
//   slave  : MDU side (drives busy/stall/done/div0 and the HI/LO registers)
//   Signals:
//     start, op[1:0]      MDU instruction valid and opcode (MULT/MULTU/DIV/DIVU)
//     rs_val, rt_val      multiplicand/dividend, multiplier/divisor
//     mfhi_req, mflo_req  EX-stage MFHI / MFLO present
//     busy, stall         operation in progress, freeze IF/ID/EX
//     done, div0          result-written pulse, divide-by-zero pulse
//     hi, lo              HI / LO registers
// ----------------------------------------------------------------------------
interface mdu_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            mfhi_req;
   logic            mflo_req;
   logic            busy;
   logic            stall;
   logic            done;
   logic            div0;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val, mfhi_req, mflo_req,
      input  busy, stall, done, div0, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, mfhi_req, mflo_req,
      output busy, stall, done, div0, hi, lo
   );
endinterface

// File: rtl/mdu_sequencer.sv
// ----------------------------------------------------------------------------
// mdu_sequencer
//   Iterative multiply/divide unit beside the EX stage; owns HI/LO.
//   MULT/MULTU use 32 shift-add steps, DIV/DIVU use 32 restoring-divide steps
//   on operand magnitudes, followed by one sign-fix cycle.
//   Ports:
//     clk  core clock
//     rst  synchronous active-high reset, dominates everything
//     mdu  slave side of mdu_sequencer_if (see interface header)
// ----------------------------------------------------------------------------
module mdu_sequencer #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32
) (
   input logic             clk,
   input logic             rst,
   mdu_sequencer_if.slave  mdu
);

   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e              r_state, w_state_nxt;
   logic [CW-1:0]       r_count, w_count_nxt;
   logic                r_is_div, w_is_div_nxt;
   logic                r_neg_q, w_neg_q_nxt;   // negate product / quotient
   logic                r_neg_r, w_neg_r_nxt;   // negate remainder
   logic                r_dz, w_dz_nxt;         // divide by zero pending
   logic [XLEN-1:0]     r_b_mag, w_b_mag_nxt;   // multiplicand / divisor magnitude
   logic [XLEN-1:0]     r_acc, w_acc_nxt;       // product high half / remainder
   logic [XLEN-1:0]     r_q, w_q_nxt;           // multiplier/product low / quotient
   logic [XLEN-1:0]     r_hi, w_hi_nxt;
   logic [XLEN-1:0]     r_lo, w_lo_nxt;
   logic                r_done, w_done_nxt;
   logic                r_div0, w_div0_nxt;

   logic                w_signed;
   logic                w_rs_neg;
   logic                w_rt_neg;
   logic [XLEN-1:0]     w_rs_mag;
   logic [XLEN-1:0]     w_rt_mag;
   logic [XLEN-1:0]     w_addend;
   logic [XLEN:0]       w_sum;
   logic [XLEN:0]       w_shift;
   logic [XLEN:0]       w_diff;
   logic [2*XLEN-1:0]   w_prod;
   logic [2*XLEN-1:0]   w_prod_fix;

   // Operand magnitudes; |-2^(XLEN-1)| wraps to itself, which is correct unsigned.
   assign w_signed = ~mdu.op[0];
   assign w_rs_neg = w_signed & mdu.rs_val[XLEN-1];
   assign w_rt_neg = w_signed & mdu.rt_val[XLEN-1];
   assign w_rs_mag = w_rs_neg ? -mdu.rs_val : mdu.rs_val;
   assign w_rt_mag = w_rt_neg ? -mdu.rt_val : mdu.rt_val;

   // Shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift {carry, acc, q} right by one.
   assign w_addend = r_q[0] ? r_b_mag : '0;
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

   // Restoring step: shift next dividend bit into the remainder, try subtract.
   assign w_shift  = {r_acc, r_q[XLEN-1]};
   assign w_diff   = w_shift - {1'b0, r_b_mag};

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_b_mag  <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_is_div <= w_is_div_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_dz     <= w_dz_nxt;
         r_b_mag  <= w_b_mag_nxt;
         r_acc    <= w_acc_nxt;
         r_q      <= w_q_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_done   <= w_done_nxt;
         r_div0   <= w_div0_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_is_div_nxt = r_is_div;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_dz_nxt     = r_dz;
      w_b_mag_nxt  = r_b_mag;
      w_acc_nxt    = r_acc;
      w_q_nxt      = r_q;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_done_nxt   = 1'b0;
      w_div0_nxt   = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (mdu.start) begin
               w_is_div_nxt = mdu.op[1];
               w_neg_q_nxt  = w_rs_neg ^ w_rt_neg;
               w_neg_r_nxt  = w_rs_neg;
               w_dz_nxt     = mdu.op[1] & (mdu.rt_val == '0);
               w_b_mag_nxt  = w_rt_mag;
               w_acc_nxt    = '0;
               w_q_nxt      = w_rs_mag;
               w_count_nxt  = '0;
               w_state_nxt  = StRun;
            end
         end

         StRun: begin
            if (r_is_div) begin
               if (!w_diff[XLEN]) begin
                  w_acc_nxt = w_diff[XLEN-1:0];
                  w_q_nxt   = {r_q[XLEN-2:0], 1'b1};
               end else begin
                  w_acc_nxt = w_shift[XLEN-1:0];
                  w_q_nxt   = {r_q[XLEN-2:0], 1'b0};
               end
            end else begin
               w_acc_nxt = w_sum[XLEN:1];
               w_q_nxt   = {w_sum[0], r_q[XLEN-1:1]};
            end
            w_count_nxt = r_count + CW'(1);
            if (r_count == CW'(ITER - 1)) begin
               w_state_nxt = StFix;
            end
         end

         StFix: begin
            if (r_is_div) begin
               // With a zero divisor the remainder path already reproduces rs_val.
               w_lo_nxt = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
               w_hi_nxt = r_neg_r ? -r_acc : r_acc;
            end else begin
               {w_hi_nxt, w_lo_nxt} = w_prod_fix;
            end
            w_done_nxt  = 1'b1;
            w_div0_nxt  = r_dz;
            w_state_nxt = StIdle;
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign mdu.busy  = (r_state != StIdle);
   assign mdu.stall = mdu.busy & (mdu.mfhi_req | mdu.mflo_req | mdu.start);
   assign mdu.done  = r_done;
   assign mdu.div0  = r_div0;
   assign mdu.hi    = r_hi;
   assign mdu.lo    = r_lo;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide controller for the pipelined MIPS core; owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU as a 32-iteration shift-add or restoring-divide sequence.
- Issues stall requests to the pipeline hazard logic when MFHI/MFLO would read a result that is not yet complete.
- Sits beside the EX stage and is started by the decoded EX-stage instruction.

Parameters:
- XLEN, 32, operand and HI/LO width
- ITER, 32, iterations per operation; must equal XLEN

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start  in  1  EX-stage MDU instruction valid; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  XLEN  multiplicand / dividend
- rt_val  in  XLEN  multiplier / divisor
- mfhi_req  in  1  EX-stage MFHI present
- mflo_req  in  1  EX-stage MFLO present
- busy  out  1  operation in progress
- stall  out  1  freeze IF/ID/EX this cycle
- done  out  1  one-cycle pulse when HI/LO are updated
- div0  out  1  pulses with done when a divide had divisor 0
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- One clock domain; all state updates on posedge clk. rst is synchronous, active-high, and dominates all other inputs.
- Reset values: state=IDLE, count=0, busy=0, stall=0, done=0, div0=0, hi=0, lo=0.
- States:
  - IDLE: on start=1, latch op, take operand magnitudes, record the result signs, set count=0 -> RUN.
  - RUN: perform one iteration per cycle, count++. After the edge where count==ITER-1 -> FIX.
  - FIX: apply sign correction, write hi/lo, set done=1 (registered) -> IDLE.
- Signed ops (MULT, DIV) use absolute values: |-2^31| = 0x80000000 treated as unsigned.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
- MULT/MULTU: {hi,lo} = 64-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
- Divisor 0: run full latency; hi=rs_val, lo=0xFFFFFFFF, div0=1 with done.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div0=0.
- Latency: start high in cycle 0 -> busy high in cycles 1..33 -> done/div0 high in cycle 34 only -> new hi/lo visible from cycle 34.
- busy = (state != IDLE). done and div0 are cleared on every edge not leaving FIX.
- stall = busy & (mfhi_req | mflo_req | start).
  - A second MDU op cannot issue while busy; start is ignored outside IDLE.
  - In the done cycle busy=0, so there is no stall and reads see the new values.
- start in the done cycle is accepted normally (back-to-back operations).
- hi/lo hold their values throughout IDLE and RUN; they change only on the FIX edge or on rst.
- rst mid-operation: abort immediately; all outputs take reset values next cycle; no partial result is written.
- No combinational path from the data inputs to hi/lo. stall is combinational from the req inputs and registered busy.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT -7 x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; then DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> div0=1 with done; hi=100, lo=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
- MULTU 3 x 5, with mflo_req held high from cycle 1 -> stall=1 in cycles 1..33; stall=0 in cycle 34 with lo=15, hi=0.
- DIVU 20 / 3 issued, then start re-asserted in the done cycle with MULTU 4 x 4 -> first result lo=6, hi=2; second done in cycle 68 with lo=16.
- MULTU 2 x 2 started, rst asserted in cycle 10 -> cycle 11 shows busy=0, hi=lo=0; done never pulses for the aborted operation.
